pipe_step_ctrl: RTL and testbench

- Parametrised run/step/breakpoint controller for the 5-stage vector pipeline. Successor to the single-button stepper.
- Produces a synchronous clock enable (pipe_en) for all pipeline stages instead of a muxed or gated clock.
- Adds debounce, N-step bursts, PC breakpoints and an enabled-cycle counter that feeds the 7-segment driver.

---
 rtl/pipe_step_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pipe_step_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_step_ctrl.sv
// pipe_step_ctrl: run / single-step / N-step / run-to-breakpoint controller for the
// 5-stage vector pipeline. Drives a synchronous clock enable rather than a gated clock.
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   step_button   raw push-button (asynchronous, active-high)
//   mode          00 free run, 01 single step, 10 N-step, 11 run-to-breakpoint
//   step_count    burst length for N-step mode (0 behaves as 1)
//   pc_f          current fetch PC
//   bp_addr       breakpoint addresses, slot i at [i*PC_W +: PC_W]
//   bp_valid      per-slot breakpoint enable
//   clr_count     synchronous clear of cycle_count (wins over increment)
//   pipe_en       pipeline clock enable
//   halted        high while in HALT
//   bp_hit        sticky per-slot record of the last breakpoint stop
//   cycle_count   number of enabled cycles, wrapping
//   state_o       HALT=00, RUN=01, STEP=10, RUN_BP=11
module pipe_step_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned PC_W            = 32,
  parameter int unsigned STEP_W          = 8,
  parameter int unsigned NUM_BP          = 2,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   step_button,
  input  logic [1:0]             mode,
  input  logic [STEP_W-1:0]      step_count,
  input  logic [PC_W-1:0]        pc_f,
  input  logic [NUM_BP*PC_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]      bp_valid,
  input  logic                   clr_count,
  output logic                   pipe_en,
  output logic                   halted,
  output logic [NUM_BP-1:0]      bp_hit,
  output logic [CNT_W-1:0]       cycle_count,
  output logic [1:0]             state_o
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    StHalt  = 2'b00,
    StRun   = 2'b01,
    StStep  = 2'b10,
    StRunBp = 2'b11
  } state_e;

  state_e             state_q;
  logic               halted_q;
  logic [NUM_BP-1:0]  bp_hit_q;
  logic [CNT_W-1:0]   cycle_count_q;
  logic [STEP_W-1:0]  remaining_q;
  logic               skip_q;

  logic               sync1_q, sync2_q;
  logic               db_q, db_prev_q;
  logic [DbW-1:0]     db_cnt_q;

  logic               press;
  logic [NUM_BP-1:0]  bp_match;
  logic               hit_any;

  assign press = db_q & ~db_prev_q;

  always_comb begin
    bp_match = '0;
    for (int unsigned i = 0; i < NUM_BP; i++) begin
      bp_match[i] = bp_valid[i] && (pc_f == bp_addr[i*PC_W +: PC_W]);
    end
  end

  assign hit_any = |bp_match;

  // Gated by the live PC compare so the pipeline never advances past a breakpoint;
  // skip lets a resume from the breakpoint PC step off it.
  assign pipe_en = (state_q == StRun) || (state_q == StStep) ||
                   ((state_q == StRunBp) && (skip_q || !hit_any));

  assign halted      = halted_q;
  assign bp_hit      = bp_hit_q;
  assign cycle_count = cycle_count_q;
  assign state_o     = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      db_q          <= 1'b0;
      db_prev_q     <= 1'b0;
      db_cnt_q      <= '0;
      state_q       <= StHalt;
      halted_q      <= 1'b1;
      bp_hit_q      <= '0;
      cycle_count_q <= '0;
      remaining_q   <= '0;
      skip_q        <= 1'b0;
    end else begin
      sync1_q   <= step_button;
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;

      // Accept a new level only after it has been stable for DEBOUNCE_CYCLES cycles.
      if (sync2_q != db_q) begin
        if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
          db_q     <= sync2_q;
          db_cnt_q <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + DbW'(1);
        end
      end else begin
        db_cnt_q <= '0;
      end

      if (clr_count) begin
        cycle_count_q <= '0;
      end else if (pipe_en) begin
        cycle_count_q <= cycle_count_q + CNT_W'(1);
      end

      unique case (state_q)
        StHalt: begin
          unique case (mode)
            2'b00: begin
              state_q  <= StRun;
              halted_q <= 1'b0;
            end
            2'b01: begin
              if (press) begin
                state_q     <= StStep;
                halted_q    <= 1'b0;
                remaining_q <= STEP_W'(1);
              end
            end
            2'b10: begin
              if (press) begin
                state_q     <= StStep;
                halted_q    <= 1'b0;
                remaining_q <= (step_count == '0) ? STEP_W'(1) : step_count;
              end
            end
            2'b11: begin
              if (press) begin
                state_q  <= StRunBp;
                halted_q <= 1'b0;
                skip_q   <= 1'b1;
                bp_hit_q <= '0;
              end
            end
          endcase
        end
        StRun: begin
          if (mode != 2'b00) begin
            state_q  <= StHalt;
            halted_q <= 1'b1;
          end
        end
        StStep: begin
          if (remaining_q == STEP_W'(1)) begin
            state_q     <= StHalt;
            halted_q    <= 1'b1;
            remaining_q <= '0;
          end else begin
            remaining_q <= remaining_q - STEP_W'(1);
          end
        end
        StRunBp: begin
          skip_q <= 1'b0;
          // A breakpoint hit takes priority over a pause request in the same cycle.
          if (!skip_q && hit_any) begin
            bp_hit_q <= bp_match;
            state_q  <= StHalt;
            halted_q <= 1'b1;
          end else if (press) begin
            state_q  <= StHalt;
            halted_q <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_step_ctrl.sv
// Directed bench for pipe_step_ctrl with a short debounce window.
module tb_pipe_step_ctrl;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned STEP_W = 8;
  localparam int unsigned NUM_BP = 2;
  localparam int unsigned CNT_W  = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   step_button;
  logic [1:0]             mode;
  logic [STEP_W-1:0]      step_count;
  logic [PC_W-1:0]        pc_f;
  logic [NUM_BP*PC_W-1:0] bp_addr;
  logic [NUM_BP-1:0]      bp_valid;
  logic                   clr_count;
  logic                   pipe_en;
  logic                   halted;
  logic [NUM_BP-1:0]      bp_hit;
  logic [CNT_W-1:0]       cycle_count;
  logic [1:0]             state_o;

  logic pc_zero;
  int   n_total = 0;
  int   n_bad   = 0;

  pipe_step_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .PC_W           (PC_W),
    .STEP_W         (STEP_W),
    .NUM_BP         (NUM_BP),
    .CNT_W          (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .step_button(step_button),
    .mode       (mode),
    .step_count (step_count),
    .pc_f       (pc_f),
    .bp_addr    (bp_addr),
    .bp_valid   (bp_valid),
    .clr_count  (clr_count),
    .pipe_en    (pipe_en),
    .halted     (halted),
    .bp_hit     (bp_hit),
    .cycle_count(cycle_count),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  // Fetch PC model: advances by 4 on every enabled cycle.
  always @(posedge clk) begin
    if (pc_zero) pc_f <= '0;
    else if (pipe_en) pc_f <= pc_f + 32'd4;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs n cycles, sampling at negedge; reports enabled-cycle count and first/last index.
  task automatic run_cycles(input int n, output int en_cnt, output int first_idx,
                            output int last_idx);
    en_cnt = 0; first_idx = 0; last_idx = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (pipe_en) begin
        en_cnt++;
        if (first_idx == 0) first_idx = i;
        last_idx = i;
      end
    end
  endtask

  // Press for 20 cycles, release, let the debouncer settle.
  task automatic press_and_count(output int en_cnt, output int first_idx, output int last_idx);
    int e2, f2, l2;
    step_button = 1'b1;
    run_cycles(20, en_cnt, first_idx, last_idx);
    step_button = 1'b0;
    run_cycles(20, e2, f2, l2);
    en_cnt += e2;
    if (first_idx == 0 && f2 != 0) first_idx = f2 + 20;
    if (l2 != 0) last_idx = l2 + 20;
  endtask

  initial begin
    int e, f, l, acc, n;
    rst = 1'b1; step_button = 1'b0; mode = 2'b00; step_count = '0;
    bp_addr = {32'h0000_0040, 32'h0000_0000}; bp_valid = '0; clr_count = 1'b0;
    pc_zero = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_pipe_en", 32'(pipe_en), 0);
    check("rst_halted", 32'(halted), 1);
    check("rst_state", 32'(state_o), 0);
    check("rst_count", 32'(cycle_count), 0);
    check("rst_bp_hit", 32'(bp_hit), 0);

    // Free run
    rst = 1'b0;
    #1 check("run_first_cycle_en", 32'(pipe_en), 0);
    @(negedge clk);
    check("run_second_cycle_en", 32'(pipe_en), 1);
    check("run_state", 32'(state_o), 1);
    check("run_count_start", 32'(cycle_count), 0);
    repeat (10) @(negedge clk);
    check("run_count_10", 32'(cycle_count), 10);

    // Asynchronous reset mid-run
    #2 rst = 1'b1;
    #1;
    check("async_rst_en", 32'(pipe_en), 0);
    check("async_rst_count", 32'(cycle_count), 0);
    check("async_rst_halted", 32'(halted), 1);
    mode = 2'b01;
    @(negedge clk);
    rst = 1'b0;

    // Glitches shorter than the debounce window
    acc = 0;
    repeat (2) begin
      step_button = 1'b1;
      run_cycles(3, e, f, l); acc += e;
      step_button = 1'b0;
      run_cycles(8, e, f, l); acc += e;
    end
    check("glitch_no_step", 32'(acc), 0);

    // Single step
    press_and_count(e, f, l);
    check("step1_en_cycles", 32'(e), 1);
    check("step1_latency", 32'(f), 7);
    check("step1_halted", 32'(halted), 1);
    check("step1_count", 32'(cycle_count), 1);

    // N-step bursts
    mode = 2'b10; step_count = 8'd5;
    press_and_count(e, f, l);
    check("burst5_en", 32'(e), 5);
    check("burst5_first", 32'(f), 7);
    check("burst5_last", 32'(l), 11);
    step_count = 8'd0;
    press_and_count(e, f, l);
    check("burst0_en", 32'(e), 1);
    step_count = 8'd5;
    step_button = 1'b1;
    acc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (pipe_en) acc++;
      if (i == 8) mode = 2'b01;
      if (i == 9) mode = 2'b11;
    end
    step_button = 1'b0;
    run_cycles(20, e, f, l); acc += e;
    check("burst_mode_toggle_en", 32'(acc), 5);
    check("burst_halted", 32'(halted), 1);
    check("burst_count", 32'(cycle_count), 12);

    // Run to breakpoint at 0x40 in slot 1
    bp_valid = 2'b10; pc_zero = 1'b1; clr_count = 1'b1;
    @(negedge clk);
    pc_zero = 1'b0; clr_count = 1'b0;
    check("bp_clr_count", 32'(cycle_count), 0);
    press_and_count(e, f, l);
    check("bp_en_cycles", 32'(e), 16);
    check("bp_hit_vec", 32'(bp_hit), 2);
    check("bp_halted", 32'(halted), 1);
    check("bp_pc", pc_f, 32'h40);
    check("bp_count", 32'(cycle_count), 16);

    // Resume from the breakpoint PC
    step_button = 1'b1;
    repeat (9) @(negedge clk);
    check("resume_state", 32'(state_o), 3);
    check("resume_bp_hit_clr", 32'(bp_hit), 0);
    check("resume_pc", pc_f, 32'h48);
    step_button = 1'b0;
    repeat (10) @(negedge clk);
    check("resume_no_rebreak", 32'(state_o), 3);

    // Pause with no hit
    step_button = 1'b1;
    repeat (6) @(negedge clk);
    check("pause_before", 32'(state_o), 3);
    @(negedge clk);
    check("pause_halted", 32'(halted), 1);
    check("pause_state", 32'(state_o), 0);
    check("pause_bp_hit", 32'(bp_hit), 0);
    step_button = 1'b0;
    repeat (10) @(negedge clk);

    // Counter wrap and clear priority
    clr_count = 1'b1; mode = 2'b00;
    @(negedge clk);
    clr_count = 1'b0;
    n = 0;
    while (cycle_count != 16'hFFFF && n < 70000) begin
      @(negedge clk);
      n++;
    end
    check("wrap_reach_ffff", 32'(cycle_count), 32'hFFFF);
    check("wrap_en", 32'(pipe_en), 1);
    @(negedge clk);
    check("wrap_to_zero", 32'(cycle_count), 0);
    repeat (3) @(negedge clk);
    check("wrap_count_3", 32'(cycle_count), 3);
    clr_count = 1'b1;
    @(negedge clk);
    check("clr_priority", 32'(cycle_count), 0);
    check("clr_en_still_on", 32'(pipe_en), 1);
    clr_count = 1'b0;
    @(negedge clk);
    check("after_clr_count", 32'(cycle_count), 1);
    mode = 2'b01;
    @(negedge clk);
    check("run_exit_halted", 32'(halted), 1);
    check("run_exit_en", 32'(pipe_en), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
